ultra_sonic_responder: RTL and testbench
========================================

ULTRA_SONIC_RESPONDER -- requirements
Module: ultra_sonic_responder

Interface
REQ-001 Parameter CLK_MHZ, default 100, system clock cycles per microsecond.
REQ-002 Parameter BURST_US, default 200, delay from trigger fall to echo rise (8-cycle 40 kHz burst time).
REQ-003 Parameter MAX_CM, default 400, largest valid distance.
REQ-004 Parameter TIMEOUT_US, default 38000, echo width for no-target response.
REQ-005 Parameter HOLDOFF_US, default 1000, dead time after echo fall.
REQ-006 clk  input  1  system clock; one clock, all logic on posedge clk.
REQ-007 reset_p  input  1  reset, asynchronous, active-high.
REQ-008 trigger  input  1  trigger pulse from the ranging initiator, synchronous to clk.
REQ-009 distance_cm  input  12  emulated target distance in cm.
REQ-010 echo  output  1  echo pulse, width = distance_cm x 58 us.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 short_trig  output  1  one-cycle pulse when a trigger shorter than 10 us is rejected.

Function
REQ-013 States IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF; echo high only in ECHO.
REQ-014 IDLE -> TRIG_HIGH on trigger rising edge; microsecond counter cleared on entry.
REQ-015 TRIG_HIGH counts whole microseconds while trigger high; on trigger falling edge: count >= 10 -> BURST, else IDLE with short_trig pulsed the same cycle.
REQ-016 distance_cm sampled into an internal register on the cycle the valid trigger falling edge is detected; later changes ignored until next measurement.
REQ-017 BURST lasts exactly BURST_US x CLK_MHZ cycles, then -> ECHO; echo rises on the first ECHO cycle.
REQ-018 ECHO lasts exactly latched_cm x 58 x CLK_MHZ cycles, then -> HOLDOFF; echo falls on the first HOLDOFF cycle.
REQ-019 Echo width arithmetic: latched_cm x 58 computed unsigned in 18 bits, microsecond counter 22 bits; no overflow for any 12-bit input.
REQ-020 latched_cm == 0 treated as 1 cm (58 us echo).
REQ-021 Out-of-range (latched_cm > MAX_CM): behaviour per REQ-029/REQ-030.
REQ-022 HOLDOFF lasts HOLDOFF_US microseconds, then -> IDLE; triggers during BURST, ECHO, HOLDOFF ignored entirely (no restart, no short_trig).
REQ-023 Trigger already high when IDLE is entered is not a rising edge; a fresh low->high transition is required.
REQ-024 Microsecond tick derived from free-running divide-by-CLK_MHZ counter restarted on every state entry, so state durations are exact in cycles.

Reset
REQ-025 reset_p high forces state IDLE, echo 0, busy 0, short_trig 0, latched distance 0, all counters 0, edge-detect history 0.
REQ-026 Reset asserted mid-ECHO drops echo to 0 asynchronously; no partial echo resumes after release.
REQ-027 First trigger rising edge accepted no earlier than the second clock after reset_p deasserts.

Configuration
REQ-028 Macro SR04_TIMEOUT_EN selects out-of-range handling.
REQ-029 With SR04_TIMEOUT_EN defined: latched_cm > MAX_CM produces echo width TIMEOUT_US microseconds (no-target response).
REQ-030 Without SR04_TIMEOUT_EN: latched_cm > MAX_CM clamped to MAX_CM (echo MAX_CM x 58 us).

Structure
REQ-031 Shared package sr04_pkg holds state enum, constant US_PER_CM = 58, minimum trigger width TRIG_MIN_US = 10.
REQ-032 One sub-module sr04_usec_tick: divide-by-CLK_MHZ counter with synchronous restart input, one-cycle tick output.
REQ-033 Trigger edge detection (one-register history) inside ultra_sonic_responder; no other sub-modules.

Verification
REQ-034 distance_cm=100, 12 us trigger -> echo rises 20000 cycles after trigger fall, high exactly 580000 cycles, busy high throughout.
REQ-035 5 us trigger -> short_trig one-cycle pulse at trigger fall, echo stays 0, busy returns 0 next cycle.
REQ-036 distance_cm=500 -> echo 3800000 cycles with SR04_TIMEOUT_EN, 2320000 cycles without.
REQ-037 distance_cm changed 100->50 during ECHO, second trigger pulsed mid-ECHO -> width stays 580000 cycles, no restart; next measurement 290000 cycles.
REQ-038 reset_p pulsed 1000 cycles into ECHO -> echo 0 immediately, busy 0; new trigger after release gives a full-width echo.
REQ-039 Back-to-back 100 ms initiator period, distance_cm=0 -> every cycle echo 5800 cycles, none missed.

Source files
------------

// File: rtl/sr04_pkg.sv
// Shared types and constants for the HC-SR04 style ultrasonic responder.
package sr04_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG_HIGH,
        ST_BURST,
        ST_ECHO,
        ST_HOLDOFF
    } sr04_state_e;

    localparam int US_PER_CM   = 58;
    localparam int TRIG_MIN_US = 10;
    localparam int CM_W        = 12;
    localparam int MUL_W       = 18;
    localparam int US_W        = 22;

endpackage

// File: rtl/sr04_usec_tick.sv
// Divide-by-CLK_MHZ counter; tick is high for one cycle per microsecond.
// restart forces the count back to zero so the next tick lands CLK_MHZ cycles later.
module sr04_usec_tick #(
    parameter int CLK_MHZ = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_W'(CLK_MHZ - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ultra_sonic_responder.sv
// Emulates an HC-SR04 ultrasonic ranger: trigger pulse in, distance-proportional echo out.
// Define SR04_TIMEOUT_EN to answer out-of-range distances with a TIMEOUT_US no-target echo.
module ultra_sonic_responder
    import sr04_pkg::*;
#(
    parameter int CLK_MHZ    = 100,
    parameter int BURST_US   = 200,
    parameter int MAX_CM     = 400,
    parameter int TIMEOUT_US = 38000,
    parameter int HOLDOFF_US = 1000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        trigger,
    input  logic [11:0] distance_cm,
    output logic        echo,
    output logic        busy,
    output logic        short_trig
);

    localparam logic [CM_W-1:0] MAX_CM_L = CM_W'(MAX_CM);

    sr04_state_e       state_q, state_d;
    logic              trig_prev_q, trig_prev_d;
    logic              armed_q, armed_d;
    logic [CM_W-1:0]   lat_cm_q, lat_cm_d;
    logic [US_W-1:0]   us_cnt_q, us_cnt_d;
    logic              short_trig_q, short_trig_d;

    logic              tick;
    logic              restart;
    logic              trig_rise;
    logic              trig_fall;
    logic [US_W-1:0]   us_elapsed;
    logic [CM_W-1:0]   eff_cm;
    logic [MUL_W-1:0]  echo_prod;
    logic [US_W-1:0]   echo_us;

    // Restarting on every state change makes each state last an exact cycle count.
    assign restart = (state_d != state_q);

    sr04_usec_tick #(
        .CLK_MHZ (CLK_MHZ)
    ) u_tick (
        .clk     (clk),
        .rst     (reset_p),
        .restart (restart),
        .tick    (tick)
    );

    assign trig_rise  = trigger & ~trig_prev_q & armed_q;
    assign trig_fall  = ~trigger & trig_prev_q;
    assign us_elapsed = us_cnt_q + US_W'(tick);

    assign echo       = (state_q == ST_ECHO);
    assign busy       = (state_q != ST_IDLE);
    assign short_trig = short_trig_q;

    always_comb begin
        eff_cm = (lat_cm_q == '0) ? CM_W'(1) : lat_cm_q;
`ifdef SR04_TIMEOUT_EN
        echo_prod = MUL_W'(eff_cm) * MUL_W'(US_PER_CM);
        echo_us   = (lat_cm_q > MAX_CM_L) ? US_W'(TIMEOUT_US) : US_W'(echo_prod);
`else
        if (lat_cm_q > MAX_CM_L) begin
            eff_cm = MAX_CM_L;
        end
        echo_prod = MUL_W'(eff_cm) * MUL_W'(US_PER_CM);
        echo_us   = US_W'(echo_prod);
`endif
    end

    always_comb begin
        state_d      = state_q;
        lat_cm_d     = lat_cm_q;
        short_trig_d = 1'b0;
        trig_prev_d  = trigger;
        armed_d      = 1'b1;
        us_cnt_d     = us_cnt_q;
        if (tick && (us_cnt_q != '1)) begin
            us_cnt_d = us_cnt_q + US_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (trig_rise) begin
                    state_d = ST_TRIG_HIGH;
                end
            end
            ST_TRIG_HIGH: begin
                if (trig_fall) begin
                    if (us_elapsed >= US_W'(TRIG_MIN_US)) begin
                        state_d  = ST_BURST;
                        lat_cm_d = distance_cm;
                    end else begin
                        state_d      = ST_IDLE;
                        short_trig_d = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (tick && (us_cnt_q == US_W'(BURST_US - 1))) begin
                    state_d = ST_ECHO;
                end
            end
            ST_ECHO: begin
                if (tick && (us_cnt_q == echo_us - US_W'(1))) begin
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (tick && (us_cnt_q == US_W'(HOLDOFF_US - 1))) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (restart) begin
            us_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q      <= ST_IDLE;
            trig_prev_q  <= 1'b0;
            armed_q      <= 1'b0;
            lat_cm_q     <= '0;
            us_cnt_q     <= '0;
            short_trig_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_prev_q  <= trig_prev_d;
            armed_q      <= armed_d;
            lat_cm_q     <= lat_cm_d;
            us_cnt_q     <= us_cnt_d;
            short_trig_q <= short_trig_d;
        end
    end

endmodule

// File: tb/tb_ultra_sonic_responder.sv
// Self-checking bench for ultra_sonic_responder with scaled-down timing parameters.
module tb_ultra_sonic_responder;

    localparam int C    = 2;
    localparam int BU   = 5;
    localparam int MAXC = 40;
    localparam int TO   = 3000;
    localparam int HO   = 10;
    localparam int B    = BU * C;
    localparam int H    = HO * C;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        trigger = 1'b0;
    logic [11:0] distance_cm = '0;
    logic        echo, busy, short_trig;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ultra_sonic_responder #(
        .CLK_MHZ    (C),
        .BURST_US   (BU),
        .MAX_CM     (MAXC),
        .TIMEOUT_US (TO),
        .HOLDOFF_US (HO)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .trigger     (trigger),
        .distance_cm (distance_cm),
        .echo        (echo),
        .busy        (busy),
        .short_trig  (short_trig)
    );

    // Expected echo width in clock cycles for a distance latched at trigger fall.
    function automatic int exp_w(input int d);
        int cm;
        cm = (d == 0) ? 1 : d;
        if (d > MAXC) begin
`ifdef SR04_TIMEOUT_EN
            return TO * C;
`else
            cm = MAXC;
`endif
        end
        return cm * 58 * C;
    endfunction

    // Called at a negedge; trigger is seen high by exactly n rising edges.
    task automatic pulse_trig(input int n);
        trigger = 1'b1;
        repeat (n) @(negedge clk);
        trigger = 1'b0;
    endtask

    // Follows one measurement from the trigger-fall edge until busy drops.
    task automatic measure(input int poke_k, input int poke_len, input logic [11:0] poke_d,
                           output int dly, output int wid, output int idle_at, output int shorts);
        dly = -1; wid = 0; idle_at = -1; shorts = 0;
        for (int k = 1; k <= 20000; k++) begin
            @(negedge clk);
            if (echo) begin
                if (dly < 0) dly = k - 1;
                wid++;
            end
            if (short_trig) shorts++;
            if (poke_k > 0 && k == poke_k) begin
                distance_cm = poke_d;
                trigger = 1'b1;
            end
            if (poke_k > 0 && poke_len > 0 && k == poke_k + poke_len) trigger = 1'b0;
            if (!busy) begin
                idle_at = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int dly, wid, idle_at, shorts;
        reset_p = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (echo !== 1'b0) begin bad++; $display("FAIL reset_echo got=%b want=0", echo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (short_trig !== 1'b0) begin bad++; $display("FAIL reset_short got=%b want=0", short_trig); end
        // trigger already high through reset release is not an edge
        trigger = 1'b1;
        @(negedge clk) reset_p = 1'b0;
        repeat (30) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_held_trig got=%b want=0", busy); end
        trigger = 1'b0;
        repeat (2) @(negedge clk);
        // trigger rising at the first clock after release is too early
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        trigger = 1'b1;
        repeat (30) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_early_trig got=%b want=0", busy); end
        trigger = 1'b0;
        // rising at the second clock after release is accepted
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_second_clk got=%b want=1", busy); end
        repeat (23) @(negedge clk);
        trigger = 1'b0;
        measure(0, 0, 12'd0, dly, wid, idle_at, shorts);
        total++; if (wid !== exp_w(0)) begin bad++; $display("FAIL reset_first_meas got=%0d want=%0d", wid, exp_w(0)); end
    endtask

    task automatic test_basic;
        int dly, wid, idle_at, shorts;
        distance_cm = 12'd25;
        pulse_trig(24);
        measure(0, 0, 12'd0, dly, wid, idle_at, shorts);
        total++; if (dly !== B) begin bad++; $display("FAIL basic_delay got=%0d want=%0d", dly, B); end
        total++; if (wid !== exp_w(25)) begin bad++; $display("FAIL basic_width got=%0d want=%0d", wid, exp_w(25)); end
        total++; if (idle_at !== 1 + B + exp_w(25) + H) begin bad++; $display("FAIL basic_busy got=%0d want=%0d", idle_at, 1 + B + exp_w(25) + H); end
        total++; if (shorts !== 0) begin bad++; $display("FAIL basic_noshort got=%0d want=0", shorts); end
    endtask

    task automatic test_short_trig;
        int dly, wid, idle_at, shorts;
        int lens[2] = '{10, 19};
        foreach (lens[i]) begin
            repeat (3) @(negedge clk);
            pulse_trig(lens[i]);
            @(negedge clk);
            total++; if (short_trig !== 1'b1) begin bad++; $display("FAIL short_pulse len=%0d got=%b want=1", lens[i], short_trig); end
            total++; if (busy !== 1'b0 || echo !== 1'b0) begin bad++; $display("FAIL short_idle len=%0d got=%b%b want=00", lens[i], busy, echo); end
            @(negedge clk);
            total++; if (short_trig !== 1'b0) begin bad++; $display("FAIL short_one_cycle len=%0d got=%b want=0", lens[i], short_trig); end
        end
        distance_cm = 12'd3;
        pulse_trig(10 * C);
        measure(0, 0, 12'd0, dly, wid, idle_at, shorts);
        total++; if (dly !== B || wid !== exp_w(3)) begin bad++; $display("FAIL short_boundary got=%0d/%0d want=%0d/%0d", dly, wid, B, exp_w(3)); end
        total++; if (shorts !== 0) begin bad++; $display("FAIL short_boundary_flag got=%0d want=0", shorts); end
    endtask

    task automatic test_range;
        int dly, wid, idle_at, shorts;
        int ds[4] = '{0, 40, 50, 4095};
        foreach (ds[i]) begin
            distance_cm = 12'(ds[i]);
            pulse_trig(24);
            measure(0, 0, 12'd0, dly, wid, idle_at, shorts);
            total++; if (wid !== exp_w(ds[i])) begin bad++; $display("FAIL range_width d=%0d got=%0d want=%0d", ds[i], wid, exp_w(ds[i])); end
        end
    endtask

    task automatic test_ignore_retrigger;
        int dly, wid, idle_at, shorts;
        distance_cm = 12'd30;
        pulse_trig(24);
        measure(B + 100, 30, 12'd15, dly, wid, idle_at, shorts);
        total++; if (wid !== exp_w(30)) begin bad++; $display("FAIL retrig_width got=%0d want=%0d", wid, exp_w(30)); end
        total++; if (idle_at !== 1 + B + exp_w(30) + H) begin bad++; $display("FAIL retrig_busy got=%0d want=%0d", idle_at, 1 + B + exp_w(30) + H); end
        total++; if (shorts !== 0) begin bad++; $display("FAIL retrig_short got=%0d want=0", shorts); end
        pulse_trig(24);
        measure(0, 0, 12'd0, dly, wid, idle_at, shorts);
        total++; if (wid !== exp_w(15)) begin bad++; $display("FAIL retrig_next got=%0d want=%0d", wid, exp_w(15)); end
        // trigger raised in holdoff and held high into idle must not start a cycle
        distance_cm = 12'd0;
        pulse_trig(24);
        measure(1 + B + exp_w(0) + 5, 0, 12'd0, dly, wid, idle_at, shorts);
        repeat (40) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_into_idle got=%b want=0", busy); end
        trigger = 1'b0;
        @(negedge clk);
        pulse_trig(24);
        measure(0, 0, 12'd0, dly, wid, idle_at, shorts);
        total++; if (dly !== B || wid !== exp_w(0)) begin bad++; $display("FAIL held_then_fresh got=%0d/%0d want=%0d/%0d", dly, wid, B, exp_w(0)); end
    endtask

    task automatic test_reset_mid_echo;
        int dly, wid, idle_at, shorts;
        bit seen;
        distance_cm = 12'd40;
        pulse_trig(24);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = echo;
        end
        total++; if (!seen) begin bad++; $display("FAIL midecho_rise got=0 want=1"); end
        repeat (1000) @(negedge clk);
        #2 reset_p = 1'b1;
        #1;
        total++; if (echo !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midecho_async got=%b%b want=00", echo, busy); end
        @(negedge clk);
        reset_p = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (echo !== 1'b0) begin bad++; $display("FAIL midecho_noresume got=%b want=0", echo); end
        pulse_trig(24);
        measure(0, 0, 12'd0, dly, wid, idle_at, shorts);
        total++; if (dly !== B || wid !== exp_w(40)) begin bad++; $display("FAIL midecho_full got=%0d/%0d want=%0d/%0d", dly, wid, B, exp_w(40)); end
    endtask

    task automatic test_back_to_back;
        int dly, wid, idle_at, shorts;
        int good;
        good = 0;
        distance_cm = 12'd0;
        for (int i = 0; i < 5; i++) begin
            pulse_trig(24);
            measure(0, 0, 12'd0, dly, wid, idle_at, shorts);
            total++; if (wid !== exp_w(0)) begin bad++; $display("FAIL b2b_width i=%0d got=%0d want=%0d", i, wid, exp_w(0)); end
            else good++;
            if (idle_at > 0 && idle_at < 376) repeat (376 - idle_at) @(negedge clk);
        end
        total++; if (good !== 5) begin bad++; $display("FAIL b2b_count got=%0d want=5", good); end
    endtask

    task automatic test_random;
        int dly, wid, idle_at, shorts;
        int d, n;
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(0, 45);
            n = $urandom_range(10, 30);
            distance_cm = 12'(d);
            repeat (2) @(negedge clk);
            pulse_trig(n);
            if (n >= 10 * C) begin
                measure(0, 0, 12'd0, dly, wid, idle_at, shorts);
                total++; if (dly !== B) begin bad++; $display("FAIL rand_delay d=%0d n=%0d got=%0d want=%0d", d, n, dly, B); end
                total++; if (wid !== exp_w(d)) begin bad++; $display("FAIL rand_width d=%0d n=%0d got=%0d want=%0d", d, n, wid, exp_w(d)); end
                total++; if (idle_at !== 1 + B + exp_w(d) + H) begin bad++; $display("FAIL rand_busy d=%0d got=%0d want=%0d", d, idle_at, 1 + B + exp_w(d) + H); end
            end else begin
                @(negedge clk);
                total++; if (short_trig !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rand_short n=%0d got=%b%b want=10", n, short_trig, busy); end
                @(negedge clk);
                total++; if (short_trig !== 1'b0) begin bad++; $display("FAIL rand_short_len n=%0d got=%b want=0", n, short_trig); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_trig();
        test_range();
        test_ignore_retrigger();
        test_reset_mid_echo();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
